// File: rtl/ddr3_mig_bridge_if.sv
// Signal bundle between the cache controller, the line bridge and the MIG user port.
// The bridge uses the slave view; the environment (controller + MIG) uses the master view.
interface ddr3_mig_bridge_if;
    logic [28:0]  addr_i;
    logic [255:0] data_i;
    logic [255:0] data_o;
    logic         we_i;
    logic         rd_i;
    logic         ack_o;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         init_calib_complete;

    modport slave (
        input  addr_i, data_i, we_i, rd_i,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete,
        output data_o, ack_o,
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
    );

    modport master (
        output addr_i, data_i, we_i, rd_i,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete,
        input  data_o, ack_o,
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask
    );
endinterface

// File: rtl/ddr3_mig_bridge.sv
// Bridges 256-bit cache-line reads/writes onto a 128-bit MIG user port as two
// back-to-back transactions, with a single ack_o pulse per line and one after calibration.
module ddr3_mig_bridge (
    input logic              clk,
    input logic              rst,
    ddr3_mig_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        StCalib,
        StIdle,
        StWrite,
        StRead,
        StAck
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [23:0]  r_addr;
    logic [255:0] r_wdata;
    logic [255:0] r_rdata;
    // Both counters run 0..2; bit 1 set means both halves are done.
    logic [1:0]   r_cmd_cnt;
    logic [1:0]   r_dat_cnt;

    logic w_latch;
    logic w_cmd_act;
    logic w_wdf_act;
    logic w_cmd_fire;
    logic w_wdf_fire;
    logic w_beat_fire;
    logic w_both_done;

    assign w_both_done = r_cmd_cnt[1] & r_dat_cnt[1];
    assign w_cmd_act   = ((r_state == StWrite) || (r_state == StRead)) && !r_cmd_cnt[1];
    assign w_wdf_act   = (r_state == StWrite) && !r_dat_cnt[1];
    assign w_cmd_fire  = w_cmd_act & bus.app_rdy;
    assign w_wdf_fire  = w_wdf_act & bus.app_wdf_rdy;
    assign w_beat_fire = (r_state == StRead) && bus.app_rd_data_valid && !r_dat_cnt[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StCalib;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        case (r_state)
            StCalib: begin
                if (bus.init_calib_complete) begin
                    w_state_next = StAck;
                end
            end
            StIdle: begin
                if (bus.we_i) begin
                    w_state_next = StWrite;
                    w_latch      = 1'b1;
                end else if (bus.rd_i) begin
                    w_state_next = StRead;
                    w_latch      = 1'b1;
                end
            end
            StWrite, StRead: begin
                if (w_both_done) begin
                    w_state_next = StAck;
                end
            end
            StAck: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StCalib;
            end
        endcase
    end

    // In READ the data counter doubles as the captured-beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_cnt <= 2'd0;
            r_dat_cnt <= 2'd0;
            r_addr    <= 24'd0;
            r_wdata   <= 256'd0;
        end else if (w_latch) begin
            r_cmd_cnt <= 2'd0;
            r_dat_cnt <= 2'd0;
            r_addr    <= bus.addr_i[28:5];
            if (bus.we_i) begin
                r_wdata <= bus.data_i;
            end
        end else begin
            if (w_cmd_fire) begin
                r_cmd_cnt <= r_cmd_cnt + 2'd1;
            end
            if (w_wdf_fire || w_beat_fire) begin
                r_dat_cnt <= r_dat_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 256'd0;
        end else if (w_beat_fire) begin
            if (r_dat_cnt[0]) begin
                r_rdata[255:128] <= bus.app_rd_data;
            end else begin
                r_rdata[127:0] <= bus.app_rd_data;
            end
        end
    end

    // Beat 1 sits 8 word-units above beat 0, i.e. address bit 3.
    assign bus.app_addr     = {r_addr, r_cmd_cnt[0], 3'b000};
    assign bus.app_cmd      = (r_state == StRead) ? 3'b001 : 3'b000;
    assign bus.app_en       = w_cmd_act;
    assign bus.app_wdf_data = r_dat_cnt[0] ? r_wdata[255:128] : r_wdata[127:0];
    assign bus.app_wdf_wren = w_wdf_act;
    assign bus.app_wdf_end  = w_wdf_act;
    assign bus.app_wdf_mask = 16'h0000;
    assign bus.ack_o        = (r_state == StAck);
    assign bus.data_o       = r_rdata;

endmodule

// File: doc/ddr3_mig_bridge.md
DDR3_MIG_BRIDGE -- requirements
Module: ddr3_mig_bridge

Interface
REQ-001 SHALL have one clock and one reset: clock clk, reset rst; reset is asynchronous and active-high.
REQ-002 SHALL provide ports (name  direction  width  meaning):
  clk  in  1  clock
  rst  in  1  async active-high reset
  addr_i  in  29  line byte address from cache controller, bits [4:0] ignored
  data_i  in  256  line write data
  data_o  out  256  line read data
  we_i  in  1  line write request, level, held until ack_o
  rd_i  in  1  line read request, level, held until ack_o
  ack_o  out  1  one-cycle completion pulse
  app_addr  out  28  MIG address, 16-bit-word units
  app_cmd  out  3  MIG command: 3'b000 write, 3'b001 read
  app_en  out  1  MIG command valid
  app_rdy  in  1  MIG command accept
  app_wdf_data  out  128  MIG write beat
  app_wdf_wren  out  1  MIG write beat valid
  app_wdf_end  out  1  last write beat of burst
  app_wdf_mask  out  16  byte mask, constant 0
  app_wdf_rdy  in  1  MIG write FIFO accept
  app_rd_data  in  128  MIG read beat
  app_rd_data_valid  in  1  read beat valid
  init_calib_complete  in  1  MIG calibration done

Function
REQ-003 SHALL split each 256-bit line into two 128-bit MIG transactions: beat 0 = line bits [127:0] at app_addr = {addr[28:5],4'h0}; beat 1 = bits [255:128] at that address + 8.
REQ-004 SHALL implement states CALIB, IDLE, WRITE, READ, ACK.
REQ-005 CALIB: no MIG activity; when init_calib_complete is 1, move to ACK. This issues exactly one ack_o pulse, which the cache controller's init state consumes.
REQ-006 IDLE: if we_i, latch addr_i[28:5] and data_i and go to WRITE. Else if rd_i, latch the address and go to READ. we_i has priority when both are asserted.
REQ-007 Inputs addr_i and data_i SHALL be sampled only on the IDLE exit edge; later changes have no effect on the transaction.
REQ-008 WRITE: a command counter (0..2) and a data counter (0..2) run independently.
  - app_en asserts while cmd count < 2; a command is accepted on app_en & app_rdy.
  - app_wdf_wren asserts while data count < 2; a beat is accepted on app_wdf_wren & app_wdf_rdy.
  - app_wdf_end equals app_wdf_wren.
  - app_addr and app_wdf_data select the beat by their own counter.
  - Go to ACK on the cycle after both counts reach 2.
REQ-009 READ:
  - Issue two read commands, same rule as WRITE.
  - Beats arrive in order. The first app_rd_data_valid writes data_o[127:0]; the second writes data_o[255:128].
  - A beat arriving before the second command is accepted SHALL be captured.
  - Go to ACK when both commands are accepted and both beats are captured.
REQ-010 ACK: ack_o = 1 for exactly one cycle, then return to IDLE. A request present in the following IDLE cycle SHALL be accepted.
REQ-011 data_o SHALL hold the last completed read line until the next read's beat capture. During a write it SHALL be unchanged.
REQ-012 Outputs app_en and app_wdf_wren SHALL be 0 in CALIB, IDLE and ACK. While asserted and not accepted, the command and data outputs SHALL hold stable.
REQ-013 app_rd_data_valid outside READ SHALL be ignored.
REQ-014 Minimum latency, with app_rdy, app_wdf_rdy and read data immediately available: write request to ack_o = 4 cycles.

Reset
REQ-015 On rst: state = CALIB, counters = 0, data_o = 0, latched address and data = 0. Outputs ack_o = 0, app_en = 0, app_wdf_wren = 0, app_wdf_end = 0, app_cmd = 0, app_addr = 0, app_wdf_data = 0, app_wdf_mask = 0.
REQ-016 Reset mid-transaction SHALL abort the transaction without an ack_o. After reset release, the block re-waits for calibration and then issues the single calibration ack_o.

Verification
REQ-017 Calib: hold init_calib_complete=0 for 50 cycles, then 1 -> exactly one ack_o pulse; no app_en or app_wdf_wren before it.
REQ-018 Write, all ready: addr_i=29'h0123_4560, data_i=256'h{1..} pattern -> two commands, app_cmd=000, at app_addr 28'h091A2B0 then 28'h091A2B8; wdf beats low half then high half; ack_o 4 cycles after request.
REQ-019 Write backpressure: app_rdy=0 for 5 cycles, app_wdf_rdy toggling -> app_en and app_wdf_data held stable while stalled; exactly 2 commands and 2 beats; single ack_o.
REQ-020 Read:
  - Return beats 128'hAAAA.. and 128'h5555.., with the first beat arriving before the second command is accepted.
  - Required: data_o = {5555..,AAAA..} when ack_o fires.
  - Required: data_o unchanged through a following write.
REQ-021 Back-to-back: write ack, then rd_i in the next cycle -> read accepted immediately. Simultaneous we_i and rd_i -> write performed.
REQ-022 Assert rst during READ after one beat -> no ack_o; outputs take reset values; calibration ack_o reissued after release.
